// File: rtl/shift_left32_sequential.sv
// Multi-cycle logical left shifter: one log-shifter stage (1, 2, 4, 8, 16) per clock,
// valid/ready handshakes on both sides, overflow flag for any '1' shifted past the MSB.
module shift_left32_sequential #(
  parameter int WIDTH = 32,
  parameter int LOG2W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             ovf,
  output logic             busy
);

  localparam int SW = (LOG2W > 1) ? $clog2(LOG2W) : 1;
  localparam logic [SW-1:0] LAST_STAGE = SW'(LOG2W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_reg;
  logic [WIDTH-1:0] data_reg;
  logic [LOG2W-1:0] amt_reg;
  logic             big_reg;
  logic             ovf_acc_reg;
  logic [SW-1:0]    stage_reg;
  logic [WIDTH-1:0] out_reg;
  logic             ovf_reg;
  logic             out_valid_reg;
  logic             busy_reg;

  logic [WIDTH-1:0] stage_data [LOG2W];
  logic             stage_lost [LOG2W];
  logic [WIDTH-1:0] data_next;
  logic             ovf_next;
  logic             accept;
  logic             apply;

  // Every stage is precomputed from the working register; the current stage picks one.
  generate
    for (genvar gi = 0; gi < LOG2W; gi++) begin : g_stage
      localparam int SH = 1 << gi;
      assign stage_data[gi] = data_reg << SH;
      assign stage_lost[gi] = |data_reg[WIDTH-1 -: SH];
    end
  endgenerate

  assign in_ready = (state_reg == IDLE) || ((state_reg == DONE) && out_ready);
  assign accept   = in_valid && in_ready;

  // Oversized shift amounts resolve at accept time; the stages then just idle.
  assign apply = amt_reg[stage_reg] && !big_reg;

  always_comb begin
    data_next = data_reg;
    ovf_next  = ovf_acc_reg;
    if (apply) begin
      data_next = stage_data[stage_reg];
      ovf_next  = ovf_acc_reg | stage_lost[stage_reg];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      data_reg      <= '0;
      amt_reg       <= '0;
      big_reg       <= 1'b0;
      ovf_acc_reg   <= 1'b0;
      stage_reg     <= '0;
      out_reg       <= '0;
      ovf_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE, DONE: begin
          if ((state_reg == DONE) && out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
          end
          if (accept) begin
            state_reg     <= SHIFT;
            busy_reg      <= 1'b1;
            out_valid_reg <= 1'b0;
            amt_reg       <= b[LOG2W-1:0];
            big_reg       <= |b[WIDTH-1:LOG2W];
            data_reg      <= (|b[WIDTH-1:LOG2W]) ? '0 : a;
            ovf_acc_reg   <= (|b[WIDTH-1:LOG2W]) && (|a);
            stage_reg     <= '0;
          end
        end
        SHIFT: begin
          data_reg    <= data_next;
          ovf_acc_reg <= ovf_next;
          stage_reg   <= stage_reg + 1'b1;
          if (stage_reg == LAST_STAGE) begin
            state_reg     <= DONE;
            busy_reg      <= 1'b0;
            out_valid_reg <= 1'b1;
            out_reg       <= data_next;
            ovf_reg       <= ovf_next;
          end
        end
        default: begin
          state_reg     <= IDLE;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign out       = out_reg;
  assign ovf       = ovf_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;

endmodule

// File: tb/tb_shift_left32_sequential.sv
// Directed and randomized checks of shift_left32_sequential against an arithmetic
// reference (64-bit widened shift) for result, overflow, latency and handshakes.
module tb_shift_left32_sequential;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out;
  logic        ovf;
  logic        busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_left32_sequential #(.WIDTH(32), .LOG2W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .out(out), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: widen to 64 bits so the shifted-out bits are simply the upper half.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] mo, output logic mv);
    logic [63:0] w;
    if (mb >= 32) begin
      mo = 32'h0;
      mv = (ma != 0);
    end else begin
      w  = {32'h0, ma} << mb;
      mo = w[31:0];
      mv = (w[63:32] != 0);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present an operand pair on the current cycle, expect acceptance on the next edge.
  task automatic accept_op(input logic [31:0] va, input logic [31:0] vb);
    a        = va;
    b        = vb;
    in_valid = 1'b1;
    #1;
    check("in_ready_at_accept", {31'b0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    a        = $urandom;
    b        = $urandom;
    check("busy_after_accept", {31'b0, busy}, 32'd1);
    check("in_ready_in_shift", {31'b0, in_ready}, 32'd0);
  endtask

  // Expect the result to appear exactly 5 edges after the accepting edge.
  task automatic expect_result(input string tag, input logic [31:0] va, input logic [31:0] vb);
    logic [31:0] eo;
    logic        ev;
    model(va, vb, eo, ev);
    for (int i = 1; i < 5; i++) begin
      check({tag, "_early_valid"}, {31'b0, out_valid}, 32'd0);
      step();
    end
    check({tag, "_valid_pre"}, {31'b0, out_valid}, 32'd0);
    step();
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_out"}, out, eo);
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, ev});
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    $display("op a=%h b=%h -> out=%h ovf=%0d (expect %h %0d)", va, vb, out, ovf, eo, ev);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("idle_after_drain", {31'b0, out_valid}, 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [31:0] va, input logic [31:0] vb);
    accept_op(va, vb);
    expect_result(tag, va, vb);
    drain();
  endtask

  initial begin
    logic [31:0] held_out;
    logic        held_ovf;
    logic [31:0] ra;
    logic [31:0] rb;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_out", out, 32'h0);
    check("reset_ovf", {31'b0, ovf}, 32'd0);
    check("reset_out_valid", {31'b0, out_valid}, 32'd0);
    check("reset_in_ready", {31'b0, in_ready}, 32'd1);
    check("reset_busy", {31'b0, busy}, 32'd0);
    $display("reset: out=%h ovf=%0d out_valid=%0d in_ready=%0d", out, ovf, out_valid, in_ready);

    run_op("t2_one_by_31", 32'h0000_0001, 32'd31);
    run_op("t3_by4", 32'hF000_000F, 32'd4);
    run_op("t3_by0", 32'hF000_000F, 32'd0);
    run_op("t4_huge", 32'h1234_5678, 32'hFFFF_FFFF);
    run_op("t4_zero_by40", 32'h0, 32'd40);
    run_op("by32", 32'h8000_0001, 32'd32);

    // Back-pressure: result must hold while out_ready is low.
    accept_op(32'hDEAD_BEEF, 32'd7);
    expect_result("t5_first", 32'hDEAD_BEEF, 32'd7);
    held_out = out;
    held_ovf = ovf;
    for (int i = 0; i < 7; i++) begin
      step();
      check("t5_hold_valid", {31'b0, out_valid}, 32'd1);
      check("t5_hold_out", out, held_out);
      check("t5_hold_ovf", {31'b0, ovf}, {31'b0, held_ovf});
      check("t5_hold_in_ready", {31'b0, in_ready}, 32'd0);
    end
    out_ready = 1'b1;
    accept_op(32'h0000_00FF, 32'd12);
    out_ready = 1'b0;
    check("t5_valid_dropped", {31'b0, out_valid}, 32'd0);
    expect_result("t5_second", 32'h0000_00FF, 32'd12);
    drain();

    // Reset in the SHIFT cycle applying stage 2 discards the operation.
    accept_op(32'hFFFF_FFFF, 32'd31);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_busy", {31'b0, busy}, 32'd0);
    check("t6_in_ready", {31'b0, in_ready}, 32'd1);
    check("t6_out", out, 32'h0);
    for (int i = 0; i < 6; i++) begin
      check("t6_no_valid", {31'b0, out_valid}, 32'd0);
      step();
    end
    run_op("t6_after_reset", 32'd3, 32'd1);

    // Randomized operations with random back-pressure and back-to-back accepts.
    for (int n = 0; n < 24; n++) begin
      ra = $urandom;
      case ($urandom_range(0, 3))
        0:       rb = $urandom_range(0, 31);
        1:       rb = $urandom_range(0, 40);
        2:       rb = $urandom;
        default: rb = 32'd1 << $urandom_range(0, 4);
      endcase
      if ($urandom_range(0, 2) == 0) ra = ra >> $urandom_range(0, 31);
      accept_op(ra, rb);
      expect_result("rand", ra, rb);
      repeat ($urandom_range(0, 2)) begin
        step();
        check("rand_hold_valid", {31'b0, out_valid}, 32'd1);
      end
      if (n % 2 == 0) begin
        drain();
      end else begin
        out_ready = 1'b1;
        ra = $urandom;
        rb = $urandom_range(0, 31);
        accept_op(ra, rb);
        out_ready = 1'b0;
        expect_result("rand_b2b", ra, rb);
        drain();
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
